// File: rtl/uart_tx_if.sv
// uart_tx_if: host-side byte handshake and serial line of uart_tx
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 serial_out;
  logic                 tx_busy;
  logic                 tx_done;
  modport master (output tx_start, tx_data, input serial_out, tx_busy, tx_done);
  modport slave (input tx_start, tx_data, output serial_out, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: async serial transmitter (start, LSB-first data, stop); define UART_TX_PARITY_EN to add an even-parity bit
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input logic       clk,
  input logic       n_rst,
  uart_tx_if.slave  bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t               state;
  logic [TW-1:0]        timer;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] sr;
  logic                 line;
  logic                 busy;
  logic                 done;
  logic                 wrap;
  assign wrap = timer == T_MAX;
  assign bus.serial_out = line;
  assign bus.tx_busy = busy;
  assign bus.tx_done = done;
  // frame sequencer: bit timer, bit index and shift register advance together; all outputs registered
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      sr    <= '0;
      line  <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done  <= 1'b0;
      timer <= (state == IDLE || wrap) ? '0 : timer + TW'(1);
      case (state)
        IDLE: if (bus.tx_start) begin
          state <= START;
          sr    <= bus.tx_data;
          busy  <= 1'b1;
          line  <= 1'b0;
`ifdef UART_TX_PARITY_EN
          par   <= ^bus.tx_data;
`endif
        end
        START: if (wrap) begin
          state <= DATA;
          idx   <= '0;
          line  <= sr[0];
        end
        DATA: if (wrap) begin
          if (idx == LAST) begin
            idx   <= '0;
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            line  <= par;
`else
            state <= STOP;
            line  <= 1'b1;
`endif
          end else begin
            idx  <= idx + 3'd1;
            sr   <= sr >> 1;
            line <= sr[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (wrap) begin
          state <= STOP;
          line  <= 1'b1;
        end
`endif
        STOP: if (wrap) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench for uart_tx against a per-bit frame model
module tb_uart_tx;
  localparam int C  = 4;
  localparam int DB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = DB + 3;
`else
  localparam int NB = DB + 2;
`endif
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  uart_tx_if #(.DATA_BITS(DB)) bus ();
  uart_tx #(.CLKS_PER_BIT(C), .DATA_BITS(DB)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DB) return d[k-1];
    if (NB == DB + 3 && k == DB + 1) return ^d;
    return 1'b1;
  endfunction
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic run_frame(input logic [7:0] d, input int lo, input int hi, input logic [7:0] noise);
    bus.tx_start = 1'b1;
    bus.tx_data  = d;
    step();
    for (int i = 1; i <= NB * C; i++) begin
      check("line", bus.serial_out, frame_bit(d, (i - 1) / C));
      check("busy", bus.tx_busy, 1);
      check("done_early", bus.tx_done, 0);
      bus.tx_start = (i >= lo && i <= hi);
      bus.tx_data  = bus.tx_start ? noise : 8'($urandom);
      step();
    end
    check("done", bus.tx_done, 1);
    check("busy_fall", bus.tx_busy, 0);
    check("line_done", bus.serial_out, 1);
  endtask
  initial begin
    bus.tx_start = 1'b0;
    bus.tx_data  = '0;
    step();
    step();
    check("rst_line", bus.serial_out, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_done", bus.tx_done, 0);
    n_rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check("idle_line", bus.serial_out, 1);
      check("idle_busy", bus.tx_busy, 0);
      check("idle_done", bus.tx_done, 0);
    end
    run_frame(8'hA5, 0, -1, 8'h00);
    bus.tx_start = 1'b0;
    step();
    check("after_done", bus.tx_done, 0);
    run_frame(8'h01, 0, -1, 8'h00);
    bus.tx_start = 1'b0;
    step();
    run_frame(8'h00, 2, 30, 8'hFF);
    bus.tx_start = 1'b0;
    step();
    check("no_requeue_busy", bus.tx_busy, 0);
    check("no_requeue_line", bus.serial_out, 1);
    check("no_requeue_done", bus.tx_done, 0);
    step();
    run_frame(8'($urandom), 0, -1, 8'h00);
    run_frame(8'h3C, 0, -1, 8'h00);
    bus.tx_start = 1'b0;
    step();
    bus.tx_start = 1'b1;
    bus.tx_data  = 8'hC3;
    step();
    bus.tx_start = 1'b0;
    repeat (17) step();
    check("mid_bit3", bus.serial_out, 0);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    check("abort_line", bus.serial_out, 1);
    check("abort_busy", bus.tx_busy, 0);
    check("abort_done", bus.tx_done, 0);
    for (int i = 0; i < NB * C; i++) begin
      step();
      check("abort_quiet_done", bus.tx_done, 0);
      check("abort_quiet_busy", bus.tx_busy, 0);
    end
    run_frame(8'h5A, 0, -1, 8'h00);
    for (int n = 0; n < 6; n++) begin
      bus.tx_start = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      run_frame(8'($urandom), 0, -1, 8'h00);
    end
    bus.tx_start = 1'b0;
    step();
    check("final_idle", bus.tx_busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter paired with the team's UART receiver. It accepts a parallel byte through a start/busy handshake and shifts it out on one line as a standard asynchronous frame: start bit, data LSB first, optional parity, stop bit. Internally it uses a bit-period timer and a bit-index counter, both with the same rollover semantics as the flexible counter. The block sits between the host-side data source and the serial line.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit; legal range 2–1023.
- `DATA_BITS`, default 8: data bits per frame; legal range 5–8.

- `clk`, input, 1: system clock; all logic is on the rising edge.
- `n_rst`, input, 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `tx_start`, input, 1: load request; honoured only while `tx_busy`=0.
- `tx_data`, input, DATA_BITS: byte to send; sampled on the accepting edge.
- `serial_out`, output, 1: serial line; idles high.
- `tx_busy`, output, 1: high while a frame is in progress.
- `tx_done`, output, 1: one-cycle pulse when a frame completes.

## Operation
- **Reset values** (first edge with `n_rst`=0):
  - state = IDLE, `serial_out`=1, `tx_busy`=0, `tx_done`=0.
  - Timer, bit index and shift register are cleared.
  - Reset overrides every other input.
- **States:** IDLE → START → DATA → [PARITY] → STOP → IDLE.
- **IDLE:**
  - `serial_out`=1.
  - On an edge with `tx_start`=1: latch `tx_data` into the shift register, go to START, set `tx_busy`=1, drive `serial_out`=0.
- **START:** `serial_out`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:**
  - `serial_out` = shift register bit 0; each bit is held CLKS_PER_BIT cycles, then the register shifts right.
  - After bit index DATA_BITS-1, go to PARITY if configured, otherwise STOP.
- **STOP:** `serial_out`=1 for CLKS_PER_BIT cycles.
  - On the final edge: go to IDLE, `tx_busy`=0, `tx_done`=1 for exactly one cycle.
- **Bit timer:**
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0 to CLKS_PER_BIT-1, then wraps to 0 and advances the bit.
  - It never exceeds CLKS_PER_BIT-1.
- **Bit index:** width 3; wraps at DATA_BITS-1.
- **`tx_start` while busy:** ignored. Neither `tx_data` nor the frame is affected, and the request is not queued.
- **Changes to `tx_data` after acceptance:** no effect on the frame in progress.
- **Reset mid-frame:** on the next edge the frame is aborted, `serial_out`=1, and no `tx_done` is produced.

## Timing
- **Start latency:** `serial_out` falls in the cycle immediately after the accepting edge (1 cycle).
- **Frame length:** `tx_busy` is high for exactly (2 + DATA_BITS [+1 with parity]) × CLKS_PER_BIT cycles.
- **`tx_done`:** asserted in the first IDLE cycle after STOP, coincident with `tx_busy` falling.
- **Back-to-back frames:**
  - `tx_start`=1 during the `tx_done` cycle is accepted.
  - The line then stays high for CLKS_PER_BIT+1 cycles between frames. This is the minimum inter-frame gap.
- **Glitches:** all outputs are registered, so `serial_out` is glitch-free.

## Configuration
- **`UART_TX_PARITY_EN` defined:**
  - A PARITY state follows DATA and lasts CLKS_PER_BIT cycles.
  - It drives even parity: XOR of the DATA_BITS latched bits.
  - Frame length becomes (3 + DATA_BITS) × CLKS_PER_BIT.
- **Undefined:** the PARITY state and its logic are absent, and the frame is (2 + DATA_BITS) × CLKS_PER_BIT.

## Test plan
All scenarios use CLKS_PER_BIT=4, DATA_BITS=8.
- **Single frame:** reset, then pulse `tx_start` with `tx_data`=0xA5.
  - `serial_out` sequence (4 cycles each): 0, 1,0,1,0,0,1,0,1, 1.
  - `tx_busy` is high for 40 cycles, and `tx_done` pulses once at cycle 41.
- **Parity:** with `UART_TX_PARITY_EN` and 0xA5, a parity bit of 0 appears after bit 7. With 0x01, the parity bit is 1. Busy lasts 44 cycles.
- **Ignored start:** hold `tx_start`=1 with 0xFF for cycles 2–30 of a 0x00 frame.
  - The frame is still all-zero data.
  - Exactly one `tx_done` occurs, and no second frame starts unless `tx_start` is still high at the `tx_done` cycle.
- **Back-to-back:** assert `tx_start` with 0x3C exactly on the `tx_done` cycle.
  - The second frame's start bit begins on the next cycle.
  - The line-high gap is 5 cycles.
- **Reset mid-frame:** drive `n_rst`=0 for one edge during data bit 3.
  - The next cycle shows `serial_out`=1, `tx_busy`=0, `tx_done`=0.
  - A subsequent 0x5A frame is transmitted correctly.
- **Idle/reset values:** with `tx_start`=0 for 100 cycles after reset, `serial_out`=1 and `tx_busy`=0 throughout.
